dram_sequencer: RTL and testbench
=================================

DRAM_SEQUENCER -- requirements
Module: dram_sequencer

Interface
REQ-001 Parameter REFRESH_INTERVAL, default 64, is the number of clk cycles between refresh requests (legal range 16..255).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 vid_req  input  1  single-cycle video fetch request.
REQ-005 vid_addr  input  14  video word address.
REQ-006 vid_ack  output  1  single-cycle pulse; video data is valid on vid_data in the same cycle.
REQ-007 vid_data  output  16  captured {hi_byte, lo_byte}.
REQ-008 cpu_req  input  1  level CPU request, held until cpu_ack.
REQ-009 cpu_we  input  1  1 = write, 0 = read.
REQ-010 cpu_addr  input  14  CPU word address.
REQ-011 cpu_hi  input  1  byte lane select: 1 = high byte, 0 = low byte.
REQ-012 cpu_nib  input  2  nibble write enables: bit0 = low nibble, bit1 = high nibble.
REQ-013 cpu_wdata  input  8  write data.
REQ-014 cpu_ack  output  1  single-cycle completion pulse.
REQ-015 cpu_rdata  output  8  read data; held until the next CPU read completes.
REQ-016 ras_n, cas_n  output  1 each  DRAM strobes, active low.
REQ-017 drwr  output  1  DRAM output-enable; low during read cycles, high otherwise.
REQ-018 drab  output  8  multiplexed row/column address.
REQ-019 wp_n  output  4  per-chip write strobes, active low (bit0 = low byte/low nibble ... bit3 = high byte/high nibble).
REQ-020 data_to_dram  output  8  write data driven to the DRAM.
REQ-021 dram_lo, dram_hi  input  8 each  raw DRAM low- and high-byte read buses.
REQ-022 vid_overrun  output  1  sticky error flag, cleared only by reset.

Function
REQ-023 Address split: row = addr[7:0]; column = {2'b00, addr[13:8]}.
REQ-024 FSM states: IDLE, ROW, COL, DATA, PRE, RROW, RHOLD.
- IDLE -> ROW when an access is granted.
- ROW -> COL -> DATA -> PRE -> IDLE for an access cycle (4 clocks of activity).
- IDLE -> RROW -> RHOLD -> PRE -> IDLE for a refresh cycle.
REQ-025 Strobes by state:
- ROW: ras_n = 0, drab = row.
- COL and DATA: ras_n = 0, cas_n = 0, drab = column.
- RROW and RHOLD: ras_n = 0, cas_n = 1, drab = refresh row counter.
- PRE and IDLE: ras_n = 1, cas_n = 1, drab = 0.
REQ-026 Write cycle: in COL and DATA, drive wp_n low for the lanes {cpu_hi, cpu_nib}; drive data_to_dram = cpu_wdata; hold drwr high.
REQ-027 Read cycle: hold drwr low from ROW through DATA.
REQ-028 Video cycles are always reads.
REQ-029 At the end of DATA:
- Video cycle: capture {dram_hi, dram_lo} into vid_data and pulse vid_ack.
- CPU cycle: pulse cpu_ack; on a read, also capture dram_hi or dram_lo (per cpu_hi) into cpu_rdata.
REQ-030 A vid_req pulse sets vid_pending and latches vid_addr; vid_pending clears on the grant.
REQ-031 If vid_req arrives while vid_pending = 1, set vid_overrun, keep the original latched address, and discard the new request.
REQ-032 Refresh counter: counts clk cycles; on reaching REFRESH_INTERVAL-1 it sets ref_pending and wraps to 0.
- The refresh row counter (8 bits, wraps 255 -> 0) increments when a refresh cycle leaves RHOLD.
REQ-033 Grant is evaluated only in IDLE. Priority: vid_pending > ref_pending > cpu_req.
REQ-034 Grants are non-preemptive: a request arriving mid-cycle waits until the cycle returns to IDLE.
REQ-035 CPU inputs are sampled at the grant; the CPU must hold them stable until cpu_ack.
REQ-036 Worst-case video latency from vid_req to vid_ack is 9 clocks (4 wait + 1 idle + 4 cycle).
REQ-037 vid_req and vid_pending may both be present in the cycle a video grant occurs; the new pulse then sets vid_pending again and is not an overrun.
REQ-038 cpu_ack is never asserted for a cycle that was not a CPU grant; vid_ack and cpu_ack are never high together.

Reset
REQ-039 While reset is high, outputs take these values immediately, independent of clk, even mid-cycle:
- ras_n = 1, cas_n = 1, drwr = 1, wp_n = 4'hF, drab = 0, data_to_dram = 0.
- vid_ack = 0, cpu_ack = 0, vid_data = 0, cpu_rdata = 0, vid_overrun = 0.
- FSM = IDLE; vid_pending, ref_pending and both counters = 0.
REQ-040 An access interrupted by reset is abandoned: no ack is issued and no write strobe is asserted after reset deasserts.

Verification
REQ-041 CPU write: cpu_we = 1, cpu_hi = 1, cpu_nib = 2'b11, addr = 14'h1234, wdata = 8'hA5 -> drab = 8'h34 then 8'h12, wp_n = 4'b0011 during COL/DATA, cpu_ack 4 clocks after grant.
REQ-042 CPU read with dram_lo = 8'h5A, cpu_hi = 0 -> drwr low ROW through DATA, cpu_rdata = 8'h5A, single cpu_ack pulse.
REQ-043 cpu_req and vid_req in the same IDLE cycle -> video served first (vid_ack), CPU ack follows 5 clocks later.
REQ-044 Two vid_req pulses 2 clocks apart during a CPU cycle -> vid_overrun = 1, exactly one vid_ack, using the first address.
REQ-045 REFRESH_INTERVAL = 16, no other traffic -> one RAS-only cycle every 16 clocks, drab = 0, 1, 2 ...; cas_n stays 1.
REQ-046 Reset asserted during COL of a write -> wp_n = 4'hF and ras_n = 1 immediately; no cpu_ack after release.

Source files
------------

// File: rtl/dram_sequencer.sv
// dram_sequencer
//   Arbitrates a single multiplexed-address DRAM between a video fetch
//   port, a CPU byte/nibble port and an internal RAS-only refresh timer.
//   Every access runs the same four-clock ROW/COL/DATA/PRE sequence. A
//   refresh runs RROW/RHOLD/PRE. Strobes are decoded directly from the
//   state register, so an asynchronous reset drops them at once.
//
// Ports
//   clk, reset              system clock, asynchronous active-high reset
//   vid_req, vid_addr       single-cycle video fetch request and word address
//   vid_ack, vid_data       fetch completion pulse and captured {hi, lo} word
//   cpu_req, cpu_we         level CPU request (held until cpu_ack), 1 = write
//   cpu_addr, cpu_hi        CPU word address and byte-lane select
//   cpu_nib, cpu_wdata      nibble write enables and write byte
//   cpu_ack, cpu_rdata      completion pulse and held read byte
//   ras_n, cas_n            DRAM strobes, active low
//   drwr                    DRAM output enable, low while reading
//   drab                    multiplexed row/column address
//   wp_n                    per-chip write strobes {hi/hi, hi/lo, lo/hi, lo/lo}
//   data_to_dram            write data to the DRAM
//   dram_lo, dram_hi        raw DRAM read buses
//   vid_overrun             sticky flag: a video request was dropped
module dram_sequencer #(
  parameter int REFRESH_INTERVAL = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  output logic        vid_ack,
  output logic [15:0] vid_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr,
  input  logic        cpu_hi,
  input  logic [1:0]  cpu_nib,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        ras_n,
  output logic        cas_n,
  output logic        drwr,
  output logic [7:0]  drab,
  output logic [3:0]  wp_n,
  output logic [7:0]  data_to_dram,
  input  logic [7:0]  dram_lo,
  input  logic [7:0]  dram_hi,
  output logic        vid_overrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ROW   = 3'd1,
    COL   = 3'd2,
    DATA  = 3'd3,
    PRE   = 3'd4,
    RROW  = 3'd5,
    RHOLD = 3'd6
  } state_t;

  localparam logic [7:0] REF_LAST = 8'(REFRESH_INTERVAL - 1);

  state_t      state;
  state_t      state_d;

  logic        vid_pending;
  logic        ref_pending;
  logic [13:0] vid_addr_q;
  logic [7:0]  ref_cnt;
  logic [7:0]  ref_row;

  // Attributes of the access in flight, captured at the grant.
  logic        cyc_vid;
  logic        cyc_we;
  logic        cyc_hi;
  logic [1:0]  cyc_nib;
  logic [13:0] cyc_addr;
  logic [7:0]  cyc_wdata;

  logic        grant_vid;
  logic        grant_ref;
  logic        grant_cpu;
  logic        vid_latch;
  logic        vid_drop;
  logic        ref_wrap;
  logic        in_access;
  logic        in_colx;
  logic        in_ref;
  logic        wr_active;

  // Active-high lane mask: the byte select picks the chip pair and the
  // nibble enables pick chips within it.
  function automatic logic [3:0] lane_mask(input logic hi, input logic [1:0] nib);
    lane_mask = hi ? {nib, 2'b00} : {2'b00, nib};
  endfunction

  always_comb begin
    state_d   = state;
    grant_vid = 1'b0;
    grant_ref = 1'b0;
    grant_cpu = 1'b0;
    unique case (state)
      IDLE: begin
        // A fresh vid_req counts as pending so that video wins even when
        // it arrives in the same IDLE cycle as a CPU request.
        if (vid_pending || vid_req) begin
          state_d   = ROW;
          grant_vid = 1'b1;
        end else if (ref_pending) begin
          state_d   = RROW;
          grant_ref = 1'b1;
        end else if (cpu_req) begin
          state_d   = ROW;
          grant_cpu = 1'b1;
        end
      end
      ROW:     state_d = COL;
      COL:     state_d = DATA;
      DATA:    state_d = PRE;
      PRE:     state_d = IDLE;
      RROW:    state_d = RHOLD;
      RHOLD:   state_d = PRE;
      default: state_d = IDLE;
    endcase
  end

  // A new pulse is latched when nothing is waiting, or when the waiting
  // request is being granted this very cycle. A pulse that finds an
  // older request still waiting is dropped and flagged.
  assign vid_latch = vid_req && (grant_vid ? vid_pending : !vid_pending);
  assign vid_drop  = vid_req && vid_pending && !grant_vid;
  assign ref_wrap  = (ref_cnt == REF_LAST);

  assign in_access = (state == ROW) || (state == COL) || (state == DATA);
  assign in_colx   = (state == COL) || (state == DATA);
  assign in_ref    = (state == RROW) || (state == RHOLD);
  assign wr_active = in_colx && cyc_we;

  always_comb begin
    ras_n        = !(in_access || in_ref);
    cas_n        = !in_colx;
    drwr         = !(in_access && !cyc_we);
    wp_n         = wr_active ? ~lane_mask(cyc_hi, cyc_nib) : 4'hF;
    data_to_dram = wr_active ? cyc_wdata : 8'h00;
    drab         = 8'h00;
    if (state == ROW) begin
      drab = cyc_addr[7:0];
    end else if (in_colx) begin
      drab = {2'b00, cyc_addr[13:8]};
    end else if (in_ref) begin
      drab = ref_row;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      vid_pending <= 1'b0;
      ref_pending <= 1'b0;
      ref_cnt     <= 8'h00;
      ref_row     <= 8'h00;
      cyc_vid     <= 1'b0;
      cyc_we      <= 1'b0;
      vid_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
      vid_data    <= 16'h0000;
      cpu_rdata   <= 8'h00;
      vid_overrun <= 1'b0;
    end else begin
      state <= state_d;

      if (grant_vid) begin
        cyc_vid <= 1'b1;
        cyc_we  <= 1'b0;
      end else if (grant_cpu) begin
        cyc_vid <= 1'b0;
        cyc_we  <= cpu_we;
      end

      vid_pending <= vid_latch || (vid_pending && !grant_vid);
      if (vid_drop) begin
        vid_overrun <= 1'b1;
      end

      // A wrap wins over a simultaneous grant so no refresh is ever lost.
      ref_cnt     <= ref_wrap ? 8'h00 : ref_cnt + 8'd1;
      ref_pending <= ref_wrap || (ref_pending && !grant_ref);
      if (state == RHOLD) begin
        ref_row <= ref_row + 8'd1;
      end

      vid_ack <= (state == DATA) && cyc_vid;
      cpu_ack <= (state == DATA) && !cyc_vid;
      if ((state == DATA) && cyc_vid) begin
        vid_data <= {dram_hi, dram_lo};
      end
      if ((state == DATA) && !cyc_vid && !cyc_we) begin
        cpu_rdata <= cyc_hi ? dram_hi : dram_lo;
      end
    end
  end

  // Address and write data only matter while the state machine says so,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (vid_latch) begin
      vid_addr_q <= vid_addr;
    end
    if (grant_vid) begin
      cyc_addr <= vid_pending ? vid_addr_q : vid_addr;
    end else if (grant_cpu) begin
      cyc_addr  <= cpu_addr;
      cyc_hi    <= cpu_hi;
      cyc_nib   <= cpu_nib;
      cyc_wdata <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_dram_sequencer.sv
module tb_dram_sequencer;

  logic        clk;
  logic        reset;
  logic        vid_req;
  logic [13:0] vid_addr;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic        cpu_hi;
  logic [1:0]  cpu_nib;
  logic [7:0]  cpu_wdata;
  logic [7:0]  dram_lo;
  logic [7:0]  dram_hi;

  logic        vid_ack;
  logic [15:0] vid_data;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        ras_n;
  logic        cas_n;
  logic        drwr;
  logic [7:0]  drab;
  logic [3:0]  wp_n;
  logic [7:0]  data_to_dram;
  logic        vid_overrun;

  // Idle-only instance with a short refresh interval.
  logic        z1;
  logic [1:0]  z2;
  logic [7:0]  z8;
  logic [13:0] z14;
  logic        r_vid_ack;
  logic [15:0] r_vid_data;
  logic        r_cpu_ack;
  logic [7:0]  r_cpu_rdata;
  logic        r_ras_n;
  logic        r_cas_n;
  logic        r_drwr;
  logic [7:0]  r_drab;
  logic [3:0]  r_wp_n;
  logic [7:0]  r_data_to_dram;
  logic        r_vid_overrun;

  int n_checks;
  int n_fail;

  dram_sequencer dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_hi(cpu_hi),
    .cpu_nib(cpu_nib), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ras_n(ras_n), .cas_n(cas_n), .drwr(drwr), .drab(drab), .wp_n(wp_n),
    .data_to_dram(data_to_dram), .dram_lo(dram_lo), .dram_hi(dram_hi),
    .vid_overrun(vid_overrun)
  );

  dram_sequencer #(.REFRESH_INTERVAL(16)) dut_r (
    .clk(clk), .reset(reset),
    .vid_req(z1), .vid_addr(z14), .vid_ack(r_vid_ack), .vid_data(r_vid_data),
    .cpu_req(z1), .cpu_we(z1), .cpu_addr(z14), .cpu_hi(z1),
    .cpu_nib(z2), .cpu_wdata(z8), .cpu_ack(r_cpu_ack), .cpu_rdata(r_cpu_rdata),
    .ras_n(r_ras_n), .cas_n(r_cas_n), .drwr(r_drwr), .drab(r_drab), .wp_n(r_wp_n),
    .data_to_dram(r_data_to_dram), .dram_lo(z8), .dram_hi(z8),
    .vid_overrun(r_vid_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    vid_req   = 1'b0;
    vid_addr  = 14'h0000;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 14'h0000;
    cpu_hi    = 1'b0;
    cpu_nib   = 2'b00;
    cpu_wdata = 8'h00;
  endtask

  // Leaves the bench at a falling edge with reset just released; the next
  // rising edge is the first one that can grant.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({ras_n, cas_n, drwr, wp_n, drab, data_to_dram} !== {1'b1, 1'b1, 1'b1, 4'hF, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b %b %b %h %h %h want 1 1 1 f 00 00",
               ras_n, cas_n, drwr, wp_n, drab, data_to_dram);
    end
    n_checks++;
    if ({vid_ack, cpu_ack, vid_data, cpu_rdata, vid_overrun} !== {1'b0, 1'b0, 16'h0000, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_regs: got %b %b %h %h %b want 0 0 0000 00 0",
               vid_ack, cpu_ack, vid_data, cpu_rdata, vid_overrun);
    end
  endtask

  task automatic test_cpu_write();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_hi = 1'b1; cpu_nib = 2'b11;
    cpu_addr = 14'h1234; cpu_wdata = 8'hA5;
    @(negedge clk);  // ROW
    n_checks++;
    if ({ras_n, cas_n, drab, wp_n, drwr} !== {1'b0, 1'b1, 8'h34, 4'hF, 1'b1}) begin
      n_fail++;
      $display("FAIL wr_row: got ras=%b cas=%b drab=%h wp=%b drwr=%b want 0 1 34 1111 1",
               ras_n, cas_n, drab, wp_n, drwr);
    end
    @(negedge clk);  // COL
    n_checks++;
    if ({ras_n, cas_n, drab, wp_n, data_to_dram, drwr} !== {1'b0, 1'b0, 8'h12, 4'b0011, 8'hA5, 1'b1}) begin
      n_fail++;
      $display("FAIL wr_col: got ras=%b cas=%b drab=%h wp=%b d=%h drwr=%b want 0 0 12 0011 a5 1",
               ras_n, cas_n, drab, wp_n, data_to_dram, drwr);
    end
    @(negedge clk);  // DATA
    n_checks++;
    if ({cas_n, wp_n, cpu_ack} !== {1'b0, 4'b0011, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_data: got cas=%b wp=%b ack=%b want 0 0011 0", cas_n, wp_n, cpu_ack);
    end
    @(negedge clk);  // PRE
    n_checks++;
    if ({cpu_ack, ras_n, wp_n, drab, data_to_dram} !== {1'b1, 1'b1, 4'hF, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL wr_pre: got ack=%b ras=%b wp=%b drab=%h d=%h want 1 1 1111 00 00",
               cpu_ack, ras_n, wp_n, drab, data_to_dram);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cpu_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_ack_pulse: got %b want 0", cpu_ack);
    end
  endtask

  task automatic test_cpu_read();
    int acks;
    int lows;
    acks = 0;
    lows = 0;
    do_reset();
    dram_lo = 8'h5A; dram_hi = 8'hC3;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_hi = 1'b0; cpu_addr = 14'h0ABC;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (drwr === 1'b0) lows++;
      if (cpu_ack === 1'b1) acks++;
      if (c == 3) begin
        n_checks++;
        if (drwr !== 1'b0) begin
          n_fail++;
          $display("FAIL rd_drwr_data: got %b want 0", drwr);
        end
      end
      if (c == 4) begin
        n_checks++;
        if ({cpu_ack, cpu_rdata, drwr} !== {1'b1, 8'h5A, 1'b1}) begin
          n_fail++;
          $display("FAIL rd_done: got ack=%b rdata=%h drwr=%b want 1 5a 1", cpu_ack, cpu_rdata, drwr);
        end
        cpu_req = 1'b0;
        dram_lo = 8'h00;
      end
    end
    n_checks++;
    if (lows !== 3) begin
      n_fail++;
      $display("FAIL rd_drwr_low_cycles: got %0d want 3", lows);
    end
    n_checks++;
    if (acks !== 1) begin
      n_fail++;
      $display("FAIL rd_ack_count: got %0d want 1", acks);
    end
    n_checks++;
    if (cpu_rdata !== 8'h5A) begin
      n_fail++;
      $display("FAIL rd_hold: got %h want 5a", cpu_rdata);
    end
  endtask

  task automatic test_priority();
    int vc;
    int cc;
    int both;
    vc = -1; cc = -1; both = 0;
    do_reset();
    dram_hi = 8'hBE; dram_lo = 8'hEF;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_hi = 1'b1; cpu_addr = 14'h0777;
    vid_req = 1'b1; vid_addr = 14'h2345;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if (drab !== 8'h45) begin
          n_fail++;
          $display("FAIL pri_first_row: got %h want 45", drab);
        end
        vid_req = 1'b0;
      end
      if (vid_ack === 1'b1 && vc < 0) begin
        vc = c;
        n_checks++;
        if (vid_data !== 16'hBEEF) begin
          n_fail++;
          $display("FAIL pri_vid_data: got %h want beef", vid_data);
        end
      end
      if (cpu_ack === 1'b1 && cc < 0) begin
        cc = c;
        cpu_req = 1'b0;
      end
      if (vid_ack === 1'b1 && cpu_ack === 1'b1) both++;
    end
    n_checks++;
    if (vc !== 4) begin
      n_fail++;
      $display("FAIL pri_vid_ack_cycle: got %0d want 4", vc);
    end
    n_checks++;
    if (cc !== 9) begin
      n_fail++;
      $display("FAIL pri_cpu_ack_cycle: got %0d want 9", cc);
    end
    n_checks++;
    if (both !== 0) begin
      n_fail++;
      $display("FAIL pri_acks_together: got %0d want 0", both);
    end
  endtask

  task automatic test_overrun();
    int vacks;
    int vc;
    vacks = 0; vc = -1;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_hi = 1'b0; cpu_nib = 2'b01;
    cpu_addr = 14'h0000; cpu_wdata = 8'h11;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (vid_ack === 1'b1) begin
        vacks++;
        if (vc < 0) vc = c;
      end
      if (cpu_ack === 1'b1) cpu_req = 1'b0;
      if (c == 6) begin
        n_checks++;
        if ({ras_n, cas_n, drab} !== {1'b0, 1'b1, 8'h11}) begin
          n_fail++;
          $display("FAIL ovr_vid_row: got ras=%b cas=%b drab=%h want 0 1 11", ras_n, cas_n, drab);
        end
      end
      if (c == 7) begin
        n_checks++;
        if (drab !== 8'h0A) begin
          n_fail++;
          $display("FAIL ovr_vid_col: got %h want 0a", drab);
        end
      end
      case (c)
        1: begin vid_req = 1'b1; vid_addr = 14'h0A11; end
        2: vid_req = 1'b0;
        3: begin vid_req = 1'b1; vid_addr = 14'h1F22; end
        4: vid_req = 1'b0;
        default: ;
      endcase
    end
    n_checks++;
    if (vid_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_flag: got %b want 1", vid_overrun);
    end
    n_checks++;
    if (vacks !== 1) begin
      n_fail++;
      $display("FAIL ovr_vid_ack_count: got %0d want 1", vacks);
    end
    n_checks++;
    if (vc !== 9) begin
      n_fail++;
      $display("FAIL ovr_vid_ack_cycle: got %0d want 9", vc);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (vid_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_cleared_by_reset: got %b want 0", vid_overrun);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back_video();
    int vacks;
    vacks = 0;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_hi = 1'b0; cpu_nib = 2'b10;
    cpu_addr = 14'h0000; cpu_wdata = 8'h22;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (vid_ack === 1'b1) vacks++;
      if (cpu_ack === 1'b1) cpu_req = 1'b0;
      if (c == 6) begin
        n_checks++;
        if (drab !== 8'h11) begin
          n_fail++;
          $display("FAIL b2b_first_row: got %h want 11", drab);
        end
      end
      if (c == 11) begin
        n_checks++;
        if ({ras_n, drab} !== {1'b0, 8'h22}) begin
          n_fail++;
          $display("FAIL b2b_second_row: got ras=%b drab=%h want 0 22", ras_n, drab);
        end
      end
      case (c)
        1: begin vid_req = 1'b1; vid_addr = 14'h0A11; end
        2: vid_req = 1'b0;
        5: begin vid_req = 1'b1; vid_addr = 14'h1F22; end
        6: vid_req = 1'b0;
        default: ;
      endcase
    end
    n_checks++;
    if (vacks !== 2) begin
      n_fail++;
      $display("FAIL b2b_vid_ack_count: got %0d want 2", vacks);
    end
    n_checks++;
    if (vid_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_overrun: got %b want 0", vid_overrun);
    end
  endtask

  task automatic test_refresh();
    int falls;
    int low;
    int cas_low;
    int hold_bad;
    int fc[4];
    logic [7:0] fd[4];
    logic prev;
    logic [7:0] prev_drab;
    falls = 0; low = 0; cas_low = 0; hold_bad = 0;
    prev = 1'b1; prev_drab = 8'h00;
    for (int i = 0; i < 4; i++) begin
      fc[i] = -1;
      fd[i] = 8'hFF;
    end
    do_reset();
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (r_cas_n !== 1'b1) cas_low++;
      if (r_ras_n === 1'b0) low++;
      if (prev === 1'b1 && r_ras_n === 1'b0) begin
        if (falls < 4) begin
          fc[falls] = c;
          fd[falls] = r_drab;
        end
        falls++;
      end else if (prev === 1'b0 && r_ras_n === 1'b0 && r_drab !== prev_drab) begin
        hold_bad++;
      end
      prev = r_ras_n;
      prev_drab = r_drab;
    end
    n_checks++;
    if (falls !== 4) begin
      n_fail++;
      $display("FAIL ref_cycle_count: got %0d want 4", falls);
    end
    n_checks++;
    if (low !== 8) begin
      n_fail++;
      $display("FAIL ref_ras_low_cycles: got %0d want 8", low);
    end
    n_checks++;
    if (cas_low !== 0) begin
      n_fail++;
      $display("FAIL ref_cas_low: got %0d want 0", cas_low);
    end
    n_checks++;
    if (hold_bad !== 0) begin
      n_fail++;
      $display("FAIL ref_row_hold: got %0d want 0", hold_bad);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (fc[i] !== 17 + 16 * i || fd[i] !== 8'(i)) begin
        n_fail++;
        $display("FAIL ref_cycle_%0d: got cycle %0d row %h want cycle %0d row %h",
                 i, fc[i], fd[i], 17 + 16 * i, 8'(i));
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int acks;
    int strobes;
    acks = 0; strobes = 0;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_hi = 1'b0; cpu_nib = 2'b10;
    cpu_addr = 14'h0155; cpu_wdata = 8'h3C;
    @(negedge clk);  // ROW
    @(negedge clk);  // COL
    n_checks++;
    if ({wp_n, data_to_dram} !== {4'b1101, 8'h3C}) begin
      n_fail++;
      $display("FAIL rst_wr_col: got wp=%b d=%h want 1101 3c", wp_n, data_to_dram);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({wp_n, ras_n, cas_n, drab, data_to_dram} !== {4'hF, 1'b1, 1'b1, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL rst_immediate: got wp=%b ras=%b cas=%b drab=%h d=%h want 1111 1 1 00 00",
               wp_n, ras_n, cas_n, drab, data_to_dram);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (cpu_ack !== 1'b0) acks++;
      if (wp_n !== 4'hF) strobes++;
    end
    n_checks++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL rst_no_ack: got %0d acks want 0", acks);
    end
    n_checks++;
    if (strobes !== 0) begin
      n_fail++;
      $display("FAIL rst_no_strobe: got %0d strobe cycles want 0", strobes);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    z1 = 1'b0; z2 = 2'b00; z8 = 8'h00; z14 = 14'h0000;
    dram_lo  = 8'h00;
    dram_hi  = 8'h00;
    clear_inputs();
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_priority();
    test_overrun();
    test_back_to_back_video();
    test_refresh();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
